// File: rtl/ecc_op_sequencer_if.sv
`default_nettype none
// =============================================================================
// Interface : ecc_op_sequencer_if
// Brief     : Control-unit / ecc-core side signals of the ecc op sequencer.
//             master = control unit plus ecc core, slave = sequencer.
// Revision  : 1.0 - initial release
// =============================================================================
interface ecc_op_sequencer_if #(
  parameter int DW = 8
);
  logic          start;
  logic [2:0]    op;
  logic          s0;
  logic [DW-1:0] x_out1, y_out1, x_out2, y_out2;
  logic [DW-1:0] c0, c1, c2, c3, c4;
  logic [2:0]    inst;
  logic [DW-1:0] a0, a1, a2, a3;
  logic [DW-1:0] b0, b1, b2, b3;
  logic [DW-1:0] x_in, y_in;
  logic          valid, busy, done, err;

  modport master (
    output start, op, s0, x_out1, y_out1, x_out2, y_out2, c0, c1, c2, c3, c4,
    input  inst, a0, a1, a2, a3, b0, b1, b2, b3, x_in, y_in, valid, busy, done, err
  );

  modport slave (
    input  start, op, s0, x_out1, y_out1, x_out2, y_out2, c0, c1, c2, c3, c4,
    output inst, a0, a1, a2, a3, b0, b1, b2, b3, x_in, y_in, valid, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/ecc_op_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : ecc_op_sequencer
// Brief    : Gathers two operand beats, issues one ecc core opcode, waits the
//            core latency and returns results as valid-qualified x/y beats.
//            Define ECC_SEQ_C4_BEAT_EN to emit c4 as a third result beat.
// Revision : 1.0 - initial release
// =============================================================================
module ecc_op_sequencer #(
  parameter int DW         = 8,
  parameter int OP_LATENCY = 4,
  parameter int LOAD_TMO   = 64
) (
  input  logic              clk,
  input  logic              reset,
  ecc_op_sequencer_if.slave bus
);

  localparam int LAT_W = (OP_LATENCY > 1) ? $clog2(OP_LATENCY) : 1;
  localparam int TMO_W = $clog2(LOAD_TMO);
  localparam logic [LAT_W-1:0] c_lat_init = LAT_W'(OP_LATENCY - 1);
  localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(LOAD_TMO - 1);
  localparam logic [2:0]       c_nop      = 3'b000;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD0 = 4'd1,
    S_LOAD1 = 4'd2,
    S_ISSUE = 4'd3,
    S_WAIT  = 4'd4,
    S_OUT0  = 4'd5,
    S_OUT1  = 4'd6,
    S_OUT2  = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  state_t         r_state;
  logic [2:0]     r_op;
  logic [2:0]     r_inst;
  logic [LAT_W-1:0] r_lat;
  logic [TMO_W-1:0] r_tmo;
  logic [DW-1:0]  r_a0, r_a1, r_a2, r_a3;
  logic [DW-1:0]  r_b0, r_b1, r_b2, r_b3;
  logic [DW-1:0]  r_res [3];
  logic [DW-1:0]  r_x_in, r_y_in;
  logic           r_valid, r_busy, r_done, r_err;

  // Outputs are registered and set on entry to the state that owns them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= c_nop;
      r_inst   <= c_nop;
      r_lat    <= '0;
      r_tmo    <= '0;
      r_a0     <= '0; r_a1 <= '0; r_a2 <= '0; r_a3 <= '0;
      r_b0     <= '0; r_b1 <= '0; r_b2 <= '0; r_b3 <= '0;
      r_res[0] <= '0; r_res[1] <= '0; r_res[2] <= '0;
      r_x_in   <= '0;
      r_y_in   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op    <= bus.op;
            r_busy  <= 1'b1;
            r_tmo   <= '0;
            r_state <= S_LOAD0;
          end
        end
        S_LOAD0: begin
          if (bus.s0) begin
            r_a0    <= bus.x_out1; r_b0 <= bus.y_out1;
            r_a1    <= bus.x_out2; r_b1 <= bus.y_out2;
            r_tmo   <= '0;
            r_state <= S_LOAD1;
          end else if (r_tmo == c_tmo_last) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_LOAD1: begin
          if (bus.s0) begin
            r_a2    <= bus.x_out1; r_b2 <= bus.y_out1;
            r_a3    <= bus.x_out2; r_b3 <= bus.y_out2;
            r_inst  <= r_op;
            r_state <= S_ISSUE;
          end else if (r_tmo == c_tmo_last) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_ISSUE: begin
          r_lat   <= c_lat_init;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // c0/c1 go straight out as the first beat; c2..c4 are held for later beats.
          if (r_lat == '0) begin
            r_res[0] <= bus.c2;
            r_res[1] <= bus.c3;
            r_res[2] <= bus.c4;
            r_x_in   <= bus.c0;
            r_y_in   <= bus.c1;
            r_valid  <= 1'b1;
            r_inst   <= c_nop;
            r_state  <= S_OUT0;
          end else begin
            r_lat <= r_lat - LAT_W'(1);
          end
        end
        S_OUT0: begin
          r_x_in  <= r_res[0];
          r_y_in  <= r_res[1];
          r_state <= S_OUT1;
        end
        S_OUT1: begin
`ifdef ECC_SEQ_C4_BEAT_EN
          r_x_in  <= r_res[2];
          r_y_in  <= '0;
          r_state <= S_OUT2;
`else
          r_valid <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
`endif
        end
        S_OUT2: begin
          r_valid <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_inst  <= c_nop;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.inst  = r_inst;
  assign bus.a0    = r_a0;
  assign bus.a1    = r_a1;
  assign bus.a2    = r_a2;
  assign bus.a3    = r_a3;
  assign bus.b0    = r_b0;
  assign bus.b1    = r_b1;
  assign bus.b2    = r_b2;
  assign bus.b3    = r_b3;
  assign bus.x_in  = r_x_in;
  assign bus.y_in  = r_y_in;
  assign bus.valid = r_valid;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ecc_op_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : tb_ecc_op_sequencer
// Brief    : Directed self-checking bench for ecc_op_sequencer.
// Revision : 1.0 - initial release
// =============================================================================
module tb_ecc_op_sequencer;

  localparam int DW         = 8;
  localparam int OP_LATENCY = 4;
  localparam int LOAD_TMO   = 64;
`ifdef ECC_SEQ_C4_BEAT_EN
  localparam int EXP_BEATS = 3;
  localparam int EXP_DONE  = 11;
`else
  localparam int EXP_BEATS = 2;
  localparam int EXP_DONE  = 10;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int tests_run    = 0;
  int tests_failed = 0;

  ecc_op_sequencer_if #(.DW(DW)) bus ();

  ecc_op_sequencer #(
    .DW(DW), .OP_LATENCY(OP_LATENCY), .LOAD_TMO(LOAD_TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [86:0] all_out;
  assign all_out = {bus.inst, bus.a0, bus.a1, bus.a2, bus.a3, bus.b0, bus.b1, bus.b2, bus.b3,
                    bus.x_in, bus.y_in, bus.valid, bus.busy, bus.done, bus.err};

  // Observations gathered by run_op.
  int         obs_done_at, obs_done_n, obs_err_n, obs_valid_n, obs_inst_cnt, obs_bad_inst;
  logic [7:0] obs_vx [4];
  logic [7:0] obs_vy [4];
  logic       obs_busy [25];
  logic [63:0] obs_ab;

  task automatic set_beats(input logic [31:0] v);
    {bus.x_out1, bus.y_out1, bus.x_out2, bus.y_out2} = v;
  endtask

  // Start at negedge 0, s0 at negedges 1 and 2, observe negedges 1..24.
  task automatic run_op(input logic [2:0] opc, input int st2_at, input logic [2:0] op2);
    obs_done_at = -1; obs_done_n = 0; obs_err_n = 0; obs_valid_n = 0;
    obs_inst_cnt = 0; obs_bad_inst = 0; obs_ab = '0;
    for (int i = 0; i < 4; i++) begin obs_vx[i] = '0; obs_vy[i] = '0; end
    @(negedge clk);
    bus.start = 1'b1; bus.op = opc;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      obs_busy[n] = bus.busy;
      if (bus.inst == opc) obs_inst_cnt++;
      else if (bus.inst != 3'b000) obs_bad_inst++;
      if (bus.valid) begin
        if (obs_valid_n < 4) begin
          obs_vx[obs_valid_n] = bus.x_in;
          obs_vy[obs_valid_n] = bus.y_in;
        end
        obs_valid_n++;
      end
      if (bus.done) begin
        obs_done_n++;
        if (obs_done_at < 0) obs_done_at = n;
      end
      if (bus.err) obs_err_n++;
      if (n == 3) obs_ab = {bus.a0, bus.a1, bus.a2, bus.a3, bus.b0, bus.b1, bus.b2, bus.b3};
      bus.start = (n == st2_at);
      bus.op    = (n == st2_at) ? op2 : opc;
      bus.s0    = (n == 1) || (n == 2);
      set_beats((n == 1) ? 32'h1234_5678 : 32'h9ABC_DEF0);
    end
    bus.start = 1'b0;
    bus.s0    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (all_out !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (all_out !== '0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got %h expected 0", all_out);
    end
  endtask

  task automatic test_basic();
    run_op(3'b001, 0, 3'b000);
    tests_run++;
    if (obs_busy[1] !== 1'b1) begin
      tests_failed++; $display("FAIL basic_busy: got %b expected 1", obs_busy[1]);
    end
    tests_run++;
    if (obs_ab !== 64'h1256_9ADE_3478_BCF0) begin
      tests_failed++; $display("FAIL basic_operands: got %h expected 12569ade3478bcf0", obs_ab);
    end
    tests_run++;
    if (obs_inst_cnt !== OP_LATENCY + 1 || obs_bad_inst !== 0) begin
      tests_failed++;
      $display("FAIL basic_inst: got %0d cycles (%0d bad) expected %0d (0 bad)",
               obs_inst_cnt, obs_bad_inst, OP_LATENCY + 1);
    end
    tests_run++;
    if (obs_valid_n !== EXP_BEATS) begin
      tests_failed++; $display("FAIL basic_beat_count: got %0d expected %0d", obs_valid_n, EXP_BEATS);
    end
    tests_run++;
    if ({obs_vx[0], obs_vy[0]} !== 16'h0102) begin
      tests_failed++; $display("FAIL basic_beat0: got %h%h expected 0102", obs_vx[0], obs_vy[0]);
    end
    tests_run++;
    if ({obs_vx[1], obs_vy[1]} !== 16'h0304) begin
      tests_failed++; $display("FAIL basic_beat1: got %h%h expected 0304", obs_vx[1], obs_vy[1]);
    end
`ifdef ECC_SEQ_C4_BEAT_EN
    tests_run++;
    if ({obs_vx[2], obs_vy[2]} !== 16'h5500) begin
      tests_failed++; $display("FAIL c4_beat: got %h%h expected 5500", obs_vx[2], obs_vy[2]);
    end
`endif
    tests_run++;
    if (obs_done_at !== EXP_DONE || obs_done_n !== 1 || obs_err_n !== 0) begin
      tests_failed++;
      $display("FAIL basic_done: got at %0d n=%0d err=%0d expected at %0d n=1 err=0",
               obs_done_at, obs_done_n, obs_err_n, EXP_DONE);
    end
    tests_run++;
`ifdef ECC_SEQ_C4_BEAT_EN
    if ({bus.busy, bus.valid, bus.x_in, bus.y_in} !== 18'h05500) begin
`else
    if ({bus.busy, bus.valid, bus.x_in, bus.y_in} !== 18'h00304) begin
`endif
      tests_failed++;
      $display("FAIL basic_hold: got busy=%b valid=%b x=%h y=%h", bus.busy, bus.valid, bus.x_in, bus.y_in);
    end
  endtask

  task automatic test_start_while_busy();
    run_op(3'b001, 5, 3'b010);
    tests_run++;
    if (obs_bad_inst !== 0 || obs_inst_cnt !== OP_LATENCY + 1) begin
      tests_failed++;
      $display("FAIL busy_inst: got %0d bad %0d good expected 0 bad %0d good",
               obs_bad_inst, obs_inst_cnt, OP_LATENCY + 1);
    end
    tests_run++;
    if (obs_done_n !== 1 || obs_done_at !== EXP_DONE || obs_busy[24] !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_done: got n=%0d at %0d busy=%b expected n=1 at %0d busy=0",
               obs_done_n, obs_done_at, obs_busy[24], EXP_DONE);
    end
  endtask

  task automatic test_load_timeout();
    int err_at = -1;
    int err_n = 0;
    int val_n = 0;
    logic busy65 = 1'b0;
    logic busy66 = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b110;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (bus.err) begin
        err_n++;
        if (err_at < 0) err_at = n;
      end
      if (bus.valid) val_n++;
      if (n == 65) busy65 = bus.busy;
      if (n == 66) busy66 = bus.busy;
      bus.start = 1'b0;
      bus.s0    = (n == 1);
      set_beats(32'h1122_3344);
    end
    bus.s0 = 1'b0;
    tests_run++;
    if (err_at !== LOAD_TMO + 2 || err_n !== 1) begin
      tests_failed++;
      $display("FAIL timeout_err: got at %0d n=%0d expected at %0d n=1", err_at, err_n, LOAD_TMO + 2);
    end
    tests_run++;
    if (busy65 !== 1'b1 || busy66 !== 1'b0 || val_n !== 0) begin
      tests_failed++;
      $display("FAIL timeout_busy: got busy65=%b busy66=%b valid=%0d expected 1 0 0", busy65, busy66, val_n);
    end
    tests_run++;
    if ({bus.a0, bus.b0, bus.a1, bus.b1, bus.a2, bus.b2, bus.a3, bus.b3} !== 64'h1122_3344_9ABC_DEF0) begin
      tests_failed++;
      $display("FAIL timeout_partial: got %h expected 112233449abcdef0",
               {bus.a0, bus.b0, bus.a1, bus.b1, bus.a2, bus.b2, bus.a3, bus.b3});
    end
  endtask

  task automatic test_reset_mid_wait();
    int stray = 0;
    @(negedge clk); bus.start = 1'b1; bus.op = 3'b101;
    @(negedge clk); bus.start = 1'b0; bus.s0 = 1'b1; set_beats(32'h1234_5678);
    @(negedge clk); set_beats(32'h9ABC_DEF0);
    @(negedge clk); bus.s0 = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.inst !== 3'b101) begin
      tests_failed++; $display("FAIL midwait_inst: got %b expected 101", bus.inst);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (all_out !== '0) begin
      tests_failed++; $display("FAIL midwait_reset: got %h expected 0", all_out);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.done || bus.err || bus.valid || bus.busy) stray++;
    end
    tests_run++;
    if (stray !== 0) begin
      tests_failed++; $display("FAIL midwait_stray: got %0d active cycles expected 0", stray);
    end
    run_op(3'b001, 0, 3'b000);
    tests_run++;
    if (obs_done_at !== EXP_DONE || {obs_vx[1], obs_vy[1]} !== 16'h0304 || obs_ab !== 64'h1256_9ADE_3478_BCF0) begin
      tests_failed++;
      $display("FAIL midwait_rerun: got done %0d beat1 %h%h ab %h", obs_done_at, obs_vx[1], obs_vy[1], obs_ab);
    end
  endtask

  task automatic test_back_to_back();
    int done_k = -1;
    logic [2:0] inst_k3 = 3'b000;
    logic [15:0] beat0 = '0;
    run_op(3'b001, EXP_DONE + 1, 3'b011);
    tests_run++;
    if (obs_done_at !== EXP_DONE || obs_busy[EXP_DONE + 1] !== 1'b0 || obs_busy[EXP_DONE + 2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_accept: got done %0d busy %b%b expected %0d busy 01",
               obs_done_at, obs_busy[EXP_DONE + 1], obs_busy[EXP_DONE + 2], EXP_DONE);
    end
    @(negedge clk);
    bus.s0 = 1'b1; set_beats(32'h1234_5678);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3) inst_k3 = bus.inst;
      if (bus.valid && beat0 == 16'h0000) beat0 = {bus.x_in, bus.y_in};
      if (bus.done && done_k < 0) done_k = k;
      bus.s0 = (k == 1);
      set_beats(32'h9ABC_DEF0);
    end
    bus.s0 = 1'b0;
    tests_run++;
    if (inst_k3 !== 3'b011 || done_k !== EXP_DONE - 1 || beat0 !== 16'h0102) begin
      tests_failed++;
      $display("FAIL b2b_second: got inst %b done %0d beat0 %h expected 011 %0d 0102",
               inst_k3, done_k, beat0, EXP_DONE - 1);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.s0    = 1'b0;
    set_beats(32'h0);
    bus.c0 = 8'h01; bus.c1 = 8'h02; bus.c2 = 8'h03; bus.c3 = 8'h04; bus.c4 = 8'h55;
    test_reset();
    test_basic();
    test_start_while_busy();
    test_load_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
